bucket_uart_sender: RTL and testbench

//  Debug-path serializer between the MIPS state bucket and the UART transmitter.
//  - On a send request it snapshots the flat bucket: GPRs, PC, data words and clock count.
//  - It streams the snapshot out one byte per UART transmission, using the tx_start/tx_done_tick handshake.
//  - The MIPS clock may resume as soon as the snapshot is taken; the snapshot is immune to later bucket changes.

---
 rtl/debug_pkg.sv | 27 ++
 rtl/bucket_uart_sender.sv | 112 +++++++++++
 tb/tb_bucket_uart_sender.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared debug-path definitions: FSM state encoding and the clogb2 helper,
// used by the bucket sender, the debug unit and the instruction loader.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_CSUM = 3'd4
  } dbg_state_e;

  // Bits needed to index `value` items; never returns less than 1 so a
  // single-byte bucket still gets a real counter.
  function automatic int clogb2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bucket_uart_sender.sv
// Snapshots the flat MIPS state bucket and streams it LSB byte first over the
// UART tx_start/tx_done_tick handshake. Define BUCKET_SENDER_CHECKSUM_EN to append an XOR checksum byte.
module bucket_uart_sender
  import debug_pkg::*;
#(
  parameter int NBIT_DATA_LEN = 8,
  parameter int LEN_BUCKET    = 448,
  parameter int N_BYTES       = LEN_BUCKET / NBIT_DATA_LEN,
  parameter int LEN_CONTADOR  = clogb2(N_BYTES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     send_start,
  input  logic [LEN_BUCKET-1:0]    bucket,
  input  logic                     tx_done_tick,
  output logic                     tx_start,
  output logic [NBIT_DATA_LEN-1:0] data_out,
  output logic                     busy,
  output logic                     done_tick
);

  // state | meaning
  // IDLE  | waiting for send_start
  // SEND  | one-cycle tx_start for snapshot byte idx
  // WAIT  | holding data_out until the UART acknowledges
  // CSUM  | one-cycle tx_start for the checksum byte (checksum build only)
  // DONE  | one-cycle done_tick, then back to IDLE

  localparam logic [LEN_CONTADOR-1:0] LAST_IDX = LEN_CONTADOR'(N_BYTES - 1);

  dbg_state_e                state_q;
  logic [LEN_BUCKET-1:0]     snapshot_q;
  logic [LEN_CONTADOR-1:0]   idx_q;
  logic [NBIT_DATA_LEN-1:0]  byte_cur;

  assign byte_cur = snapshot_q[idx_q*NBIT_DATA_LEN +: NBIT_DATA_LEN];

`ifdef BUCKET_SENDER_CHECKSUM_EN
  logic [NBIT_DATA_LEN-1:0] csum_q;
  logic                     csum_phase_q;

  assign tx_start = (state_q == ST_SEND) || (state_q == ST_CSUM);
  assign data_out = csum_phase_q ? csum_q : byte_cur;
`else
  assign tx_start = (state_q == ST_SEND);
  assign data_out = byte_cur;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign done_tick = (state_q == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      snapshot_q   <= '0;
      idx_q        <= '0;
`ifdef BUCKET_SENDER_CHECKSUM_EN
      csum_q       <= '0;
      csum_phase_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // tx_done_tick in this state is deliberately not looked at
          if (send_start) begin
            snapshot_q <= bucket;
            idx_q      <= '0;
            state_q    <= ST_SEND;
`ifdef BUCKET_SENDER_CHECKSUM_EN
            csum_q       <= '0;
            csum_phase_q <= 1'b0;
`endif
          end
        end
        ST_SEND: begin
`ifdef BUCKET_SENDER_CHECKSUM_EN
          csum_q <= csum_q ^ byte_cur;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done_tick) begin
`ifdef BUCKET_SENDER_CHECKSUM_EN
            if (csum_phase_q) begin
              state_q <= ST_DONE;
            end else if (idx_q == LAST_IDX) begin
              csum_phase_q <= 1'b1;
              state_q      <= ST_CSUM;
            end else begin
              idx_q   <= idx_q + LEN_CONTADOR'(1);
              state_q <= ST_SEND;
            end
`else
            if (idx_q == LAST_IDX) begin
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + LEN_CONTADOR'(1);
              state_q <= ST_SEND;
            end
`endif
          end
        end
`ifdef BUCKET_SENDER_CHECKSUM_EN
        ST_CSUM: state_q <= ST_WAIT;
`endif
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bucket_uart_sender.sv
// Randomized bench for bucket_uart_sender: a UART responder model acks each byte,
// and the received stream is compared with the byte list built from the bucket image.
module tb_bucket_uart_sender;

  localparam int NB = 56;

  logic         clk = 1'b0;
  logic         reset;
  logic         send_start;
  logic [447:0] bucket;
  logic         tx_done_tick;
  logic         tx_start;
  logic [7:0]   data_out;
  logic         busy;
  logic         done_tick;

  int total = 0;
  int bad   = 0;

  logic [7:0] img[NB];
  logic [7:0] got[$];
  int ndone, hold_ok, busy_ok, after_busy, finished;

  always #5 clk = ~clk;

  bucket_uart_sender dut (
    .clk          (clk),
    .reset        (reset),
    .send_start   (send_start),
    .bucket       (bucket),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .data_out     (data_out),
    .busy         (busy),
    .done_tick    (done_tick)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [447:0] pack_img();
    logic [447:0] b;
    for (int i = 0; i < NB; i++) b[i*8 +: 8] = img[i];
    return b;
  endfunction

  task automatic random_img();
    for (int i = 0; i < NB; i++) img[i] = 8'($urandom_range(0, 255));
  endtask

  // Starts a dump at the current negedge and plays the UART side.
  // abort_at >= 0: pull reset low while waiting on that byte index and return.
  task automatic run_dump(input int delay, input bit clobber, input bit extra_starts,
                          input bit spurious, input bit ack_with_start, input int abort_at);
    int cnt, post;
    bit f5, f40;
    got.delete();
    ndone = 0; hold_ok = 1; busy_ok = 1; after_busy = 1; finished = 0;
    cnt = 0; post = -1; f5 = 0; f40 = 0;
    bucket       = pack_img();
    send_start   = 1'b1;
    tx_done_tick = ack_with_start;
    @(negedge clk);
    send_start   = 1'b0;
    tx_done_tick = 1'b0;
    if (clobber) bucket = '1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tx_done_tick = 1'b0;
      send_start   = 1'b0;
      if (done_tick) begin
        ndone++;
        if (post < 0) post = 0;
      end else if (post >= 0) begin
        post++;
      end
      if (post == 1 && busy) after_busy = 0;
      if (post < 0 && !busy) busy_ok = 0;
      if (tx_start) begin
        got.push_back(data_out);
        cnt = delay;
        if (spurious && got.size() == 3) tx_done_tick = 1'b1;
      end else if (cnt > 0) begin
        if (data_out !== got[$]) hold_ok = 0;
        if (abort_at >= 0 && got.size() == abort_at + 1) begin
          reset = 1'b0;
          #1;
          check_val("rst_tx_start", {31'd0, tx_start}, 0);
          check_val("rst_busy", {31'd0, busy}, 0);
          check_val("rst_done_tick", {31'd0, done_tick}, 0);
          check_val("rst_data_out", {24'd0, data_out}, 0);
          return;
        end
        if (extra_starts && got.size() == 5 && !f5) begin send_start = 1'b1; f5 = 1; end
        if (extra_starts && got.size() == 40 && !f40) begin send_start = 1'b1; f40 = 1; end
        cnt--;
        if (cnt == 0) tx_done_tick = 1'b1;
      end
      if (post == 4) break;
      @(negedge clk);
    end
    tx_done_tick = 1'b0;
    send_start   = 1'b0;
    finished = (post >= 0) ? 1 : 0;
  endtask

  task automatic verify(input string name);
    logic [7:0] exp[$];
    logic [7:0] x;
    int n;
    x = 8'h00;
    for (int i = 0; i < NB; i++) begin
      exp.push_back(img[i]);
      x = x ^ img[i];
    end
`ifdef BUCKET_SENDER_CHECKSUM_EN
    exp.push_back(x);
`endif
    check_val({name, "_finished"}, finished, 1);
    check_val({name, "_count"}, got.size(), exp.size());
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++)
      check_val($sformatf("%s_byte%0d", name, i), {24'd0, got[i]}, {24'd0, exp[i]});
    check_val({name, "_done_ticks"}, ndone, 1);
    check_val({name, "_hold"}, hold_ok, 1);
    check_val({name, "_busy_during"}, busy_ok, 1);
    check_val({name, "_busy_after"}, after_busy, 1);
  endtask

  initial begin
    reset        = 1'b0;
    send_start   = 1'b0;
    tx_done_tick = 1'b0;
    bucket       = '0;
    repeat (3) @(negedge clk);
    check_val("reset_tx_start", {31'd0, tx_start}, 0);
    check_val("reset_busy", {31'd0, busy}, 0);
    check_val("reset_done_tick", {31'd0, done_tick}, 0);
    check_val("reset_data_out", {24'd0, data_out}, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NB; i++) img[i] = 8'(i);
    run_dump(3, 0, 0, 0, 0, -1);
    verify("ramp");

    random_img();
    run_dump(2, 0, 0, 0, 0, 10);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    random_img();
    run_dump(3, 0, 0, 0, 0, -1);
    verify("after_reset");

    random_img();
    run_dump(2, 1, 0, 0, 0, -1);
    verify("clobber");

    random_img();
    run_dump(3, 0, 1, 0, 0, -1);
    verify("extra_start");

    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    check_val("idle_ack_busy", {31'd0, busy}, 0);
    check_val("idle_ack_tx_start", {31'd0, tx_start}, 0);
    @(negedge clk);
    random_img();
    run_dump(4, 0, 0, 1, 1, -1);
    verify("spurious");

    for (int i = 0; i < NB; i++) img[i] = 8'h00;
    img[0] = 8'h5A;
    img[1] = 8'h0F;
    run_dump(3, 0, 0, 0, 0, -1);
    verify("csum_img");
`ifdef BUCKET_SENDER_CHECKSUM_EN
    if (got.size() == NB + 1) check_val("csum_value", {24'd0, got[NB]}, 32'h55);
`endif

    for (int r = 0; r < 3; r++) begin
      random_img();
      run_dump(int'($urandom_range(1, 5)), 0, 0, 0, 0, -1);
      verify($sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
